// File: rtl/instr_enc_pkg.sv
// Shared opcode/funct constants and the request-op enumeration for the
// instruction encoder and control decoder.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MULT = 3'd3,
        OP_ADDI = 3'd4,
        OP_MUL  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } req_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } enc_state_e;

    localparam logic [5:0] OPC_SPECIAL  = 6'b000000;
    localparam logic [5:0] OPC_ADDI     = 6'b001000;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_MUL  = 6'b000010;

    function automatic logic [31:0] r_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [5:0] fn);
        return {opc, rs, rt, rd, 5'b00000, fn};
    endfunction

endpackage

// File: rtl/instr_enc_fields.sv
// Combinational op + register fields -> 32-bit instruction word and legal flag.
// MUL (op 5) is only legal when INSTR_ENC_MUL_EN is defined.
module instr_enc_fields (
    input  logic [2:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal
);
    import instr_enc_pkg::*;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (req_op_e'(op))
            OP_NOP:  word = '0;
            OP_ADD:  word = r_type(OPC_SPECIAL, rs, rt, rd, FN_ADD);
            OP_SUB:  word = r_type(OPC_SPECIAL, rs, rt, rd, FN_SUB);
            OP_MULT: word = r_type(OPC_SPECIAL, rs, rt, 5'd0, FN_MULT);
            OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
`ifdef INSTR_ENC_MUL_EN
            OP_MUL:  word = r_type(OPC_SPECIAL2, rs, rt, rd, FN_MUL);
`else
            OP_MUL:  legal = 1'b0;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Request-driven instruction encoder writing one word per accepted request
// into instruction memory; optional MUL support via INSTR_ENC_MUL_EN.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CLEAR,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [2:0]        REQ_OP,
    input  logic [4:0]        REQ_RS,
    input  logic [4:0]        REQ_RT,
    input  logic [4:0]        REQ_RD,
    input  logic [15:0]       REQ_IMM,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DATA,
    output logic              ILLEGAL,
    output logic              FULL,
    output logic [ADDR_W:0]   COUNT
);
    import instr_enc_pkg::*;

    enc_state_e  state, state_nxt;
    logic [31:0] enc_word;
    logic        enc_legal;
    logic        handshake;

    instr_enc_fields u_fields (
        .op    (REQ_OP),
        .rs    (REQ_RS),
        .rt    (REQ_RT),
        .rd    (REQ_RD),
        .imm   (REQ_IMM),
        .word  (enc_word),
        .legal (enc_legal)
    );

    // COUNT never exceeds 2^ADDR_W, so its top bit is the full flag and its
    // low bits are the write pointer.
    assign FULL      = COUNT[ADDR_W];
    assign handshake = REQ_VALID && REQ_READY;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (CLEAR) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (handshake && enc_legal) state_nxt = ST_WRITE;
                ST_WRITE: state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        REQ_READY = (state == ST_IDLE) && !FULL && !CLEAR;
        MEM_WE    = (state == ST_WRITE) && !CLEAR;
    end

    // Address/data are captured at the handshake, so they only change on
    // entry to WRITE and otherwise hold the last presented values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MEM_ADDR <= '0;
            MEM_DATA <= '0;
            ILLEGAL  <= 1'b0;
            COUNT    <= '0;
        end else begin
            ILLEGAL <= handshake && !enc_legal;
            if (handshake && enc_legal) begin
                MEM_ADDR <= COUNT[ADDR_W-1:0];
                MEM_DATA <= enc_word;
            end
            if (CLEAR)              COUNT <= '0;
            else if (MEM_WE)        COUNT <= COUNT + (ADDR_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          CLEAR = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic [2:0]    REQ_OP = '0;
    logic [4:0]    REQ_RS = '0, REQ_RT = '0, REQ_RD = '0;
    logic [15:0]   REQ_IMM = '0;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [31:0]   MEM_DATA;
    logic          ILLEGAL;
    logic          FULL;
    logic [AW:0]   COUNT;

    instr_encoder #(.ADDR_W(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_RS(REQ_RS), .REQ_RT(REQ_RT), .REQ_RD(REQ_RD), .REQ_IMM(REQ_IMM),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
        .ILLEGAL(ILLEGAL), .FULL(FULL), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model state: a pending write, words written, illegal pulse, held addr/data.
    bit          m_pending, m_illegal;
    int          m_count;
    int unsigned m_addr, m_data;
    int unsigned wr_addrs[$];

    logic        s_ready, s_we, s_ill, s_full;
    logic [31:0] s_addr, s_data, s_count;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] exp_word;
        bit          exp_legal;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned rfmt(int unsigned opc, int unsigned rs, int unsigned rt,
                                         int unsigned rd, int unsigned fn);
        return opc * (2**26) + rs * (2**21) + rt * (2**16) + rd * (2**11) + fn;
    endfunction

    function automatic bit ref_legal(input logic [2:0] op);
`ifdef INSTR_ENC_MUL_EN
        return op <= 3'd5;
`else
        return op <= 3'd4;
`endif
    endfunction

    function automatic int unsigned ref_word(input logic [2:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [15:0] imm);
        int unsigned a = rs, b = rt, d = rd, i = imm;
        case (op)
            3'd1:    return rfmt(0, a, b, d, 32);
            3'd2:    return rfmt(0, a, b, d, 34);
            3'd3:    return rfmt(0, a, b, 0, 24);
            3'd4:    return 8 * (2**26) + a * (2**21) + b * (2**16) + i;
            3'd5:    return rfmt(28, a, b, d, 2);
            default: return 0;
        endcase
    endfunction

    task automatic m_reset();
        m_pending = 0; m_illegal = 0; m_count = 0; m_addr = 0; m_data = 0;
    endtask

    // Called just after a rising edge: drive, check at the falling edge, step the model.
    task automatic cycle(input bit v, input logic [2:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input bit clr);
        bit e_ready, e_we, hs;
        REQ_VALID = v; REQ_OP = op; REQ_RS = rs; REQ_RT = rt; REQ_RD = rd;
        REQ_IMM = imm; CLEAR = clr;
        @(negedge CLK);
        s_ready = REQ_READY; s_we = MEM_WE; s_ill = ILLEGAL; s_full = FULL;
        s_addr = 32'(MEM_ADDR); s_data = MEM_DATA; s_count = 32'(COUNT);
        e_ready = !m_pending && (m_count < DEPTH) && !clr;
        e_we    = m_pending && !clr;
        chk("ready", 32'(s_ready), 32'(e_ready));
        chk("mem_we", 32'(s_we), 32'(e_we));
        chk("mem_addr", s_addr, m_addr);
        chk("mem_data", s_data, m_data);
        chk("illegal", 32'(s_ill), 32'(m_illegal));
        chk("count", s_count, 32'(m_count));
        chk("full", 32'(s_full), 32'(m_count == DEPTH));
        if (s_we) wr_addrs.push_back(s_addr);
        hs = v && e_ready;
        if (clr) begin
            m_pending = 0; m_count = 0; m_illegal = 0;
        end else begin
            m_illegal = hs && !ref_legal(op);
            if (m_pending) begin
                m_count++; m_pending = 0;
            end else if (hs && ref_legal(op)) begin
                m_pending = 1; m_addr = m_count; m_data = ref_word(op, rs, rt, rd, imm);
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic idle();
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 0);
    endtask

    task automatic do_clear();
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        m_reset();

        // Reset state
        #2;
        chk("rst_we", 32'(MEM_WE), 0);
        chk("rst_addr", 32'(MEM_ADDR), 0);
        chk("rst_data", MEM_DATA, 0);
        chk("rst_ill", 32'(ILLEGAL), 0);
        chk("rst_count", 32'(COUNT), 0);
        chk("rst_full", 32'(FULL), 0);
        chk("rst_ready", 32'(REQ_READY), 1);
        @(posedge CLK); #1;
        RESET_N = 1'b1;

        // First edge after release accepts ADD rs=1 rt=2 rd=3
        cycle(1, 3'd1, 5'd1, 5'd2, 5'd3, 16'h0, 0);
        idle();
        chk("add_we", 32'(s_we), 1);
        chk("add_addr", s_addr, 0);
        chk("add_data", s_data, 32'h00221820);
        idle();
        chk("add_count", s_count, 1);

        // Vector table
        vecs.push_back('{3'd4, 5'd4, 5'd5, 5'd0, 16'hFFFF, 32'h2085FFFF, 1});
        vecs.push_back('{3'd4, 5'd0, 5'd31, 5'd9, 16'h1234, 32'h201F1234, 1});
        vecs.push_back('{3'd0, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 32'h0, 1});
        vecs.push_back('{3'd2, 5'd31, 5'd31, 5'd31, 16'h0, 32'h03FFF822, 1});
        vecs.push_back('{3'd3, 5'd7, 5'd9, 5'd31, 16'h0, 32'h00E90018, 1});
        vecs.push_back('{3'd6, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0});
        vecs.push_back('{3'd7, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0});
`ifdef INSTR_ENC_MUL_EN
        vecs.push_back('{3'd5, 5'd1, 5'd2, 5'd3, 16'h0, 32'h70221802, 1});
`else
        vecs.push_back('{3'd5, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0});
`endif
        foreach (vecs[k]) begin
            do_clear();
            cycle(1, vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].imm, 0);
            idle();
            chk("vec_we", 32'(s_we), 32'(vecs[k].exp_legal));
            chk("vec_ill", 32'(s_ill), 32'(!vecs[k].exp_legal));
            if (vecs[k].exp_legal) chk("vec_word", s_data, vecs[k].exp_word);
            idle();
            chk("vec_count", s_count, 32'(vecs[k].exp_legal));
            chk("vec_ill_off", 32'(s_ill), 0);
        end

        // Fill to FULL with back-to-back requests; fifth stalls
        do_clear();
        wr_addrs.delete();
        for (int i = 0; i < 12; i++) cycle(1, 3'd1, 5'(i), 5'd2, 5'd3, 16'h0, 0);
        chk("full_nwr", 32'(wr_addrs.size()), DEPTH);
        for (int i = 0; i < DEPTH && i < wr_addrs.size(); i++) chk("full_addr", wr_addrs[i], i);
        chk("full_flag", 32'(s_full), 1);
        chk("full_ready", 32'(s_ready), 0);
        chk("full_count", s_count, DEPTH);
        do_clear();
        cycle(1, 3'd2, 5'd1, 5'd1, 5'd1, 16'h0, 0);
        idle();
        chk("clr_we", 32'(s_we), 1);
        chk("clr_addr", s_addr, 0);

        // CLEAR during WRITE discards the word
        cycle(1, 3'd1, 5'd1, 5'd2, 5'd3, 16'h0, 0);
        cycle(0, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 1);
        chk("clrw_we", 32'(s_we), 0);
        idle();
        chk("clrw_count", s_count, 0);

        // CLEAR beats a simultaneous request
        cycle(1, 3'd1, 5'd4, 5'd4, 5'd4, 16'h0, 1);
        chk("clrhs_ready", 32'(s_ready), 0);
        idle();
        chk("clrhs_we", 32'(s_we), 0);

        // Reset asserted while in WRITE
        cycle(1, 3'd1, 5'd5, 5'd6, 5'd7, 16'h0, 0);
        RESET_N = 1'b0; REQ_VALID = 1'b0;
        #1;
        chk("rstw_we", 32'(MEM_WE), 0);
        chk("rstw_addr", 32'(MEM_ADDR), 0);
        chk("rstw_data", MEM_DATA, 0);
        chk("rstw_count", 32'(COUNT), 0);
        chk("rstw_ill", 32'(ILLEGAL), 0);
        chk("rstw_ready", 32'(REQ_READY), 1);
        m_reset();
        @(negedge CLK);
        chk("rstw_we_hold", 32'(MEM_WE), 0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), 3'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 16'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
